sysreg_spr_ctrl: RTL and testbench

- Sequences every update of the stack-pointer system register (SPR).
- Arbitrates three sources onto the SPR register's single write port:
  - execute-stage set/add/sub commands;
  - exception-entry switch to the kernel stack;
  - exception-return restore of the saved user stack.
- Keeps a one-entry shadow of the interrupted SPR and forwards its own pending write, so back-to-back relative updates are correct.
- Sits in the execute unit beside the SPR register: drives that register's regist request/data and reads back its info output.

---
 rtl/sysreg_spr_ctrl_pkg.sv | 31 +++
 rtl/sysreg_spr_alu.sv | 27 ++
 rtl/sysreg_spr_ctrl.sv | 136 +++++++++++++
 tb/tb_sysreg_spr_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysreg_spr_ctrl_pkg.sv
// Shared definitions for the SPR update sequencer: command encodings,
// state encodings and a small command decode helper.
package sysreg_spr_ctrl_pkg;

  localparam int SPR_W = 32;

  typedef enum logic [1:0] {
    EXE_CMD_SET = 2'b00,
    EXE_CMD_ADD = 2'b01,
    EXE_CMD_SUB = 2'b10,
    EXE_CMD_NOP = 2'b11
  } exe_cmd_e;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ENTRY_SAVE = 2'd1;
  localparam logic [1:0] ST_ENTRY_LOAD = 2'd2;
  localparam logic [1:0] ST_RET_LOAD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    ENTRY_SAVE = ST_ENTRY_SAVE,
    ENTRY_LOAD = ST_ENTRY_LOAD,
    RET_LOAD   = ST_RET_LOAD
  } state_e;

  // The reserved encoding is accepted but never produces a register write.
  function automatic logic cmd_writes(input logic [1:0] cmd);
    return cmd != EXE_CMD_NOP;
  endfunction

endpackage

// File: rtl/sysreg_spr_alu.sv
// Combinational set/add/sub of an operand against the current SPR base.
// Arithmetic wraps modulo 2^N; carry and borrow are dropped.
module sysreg_spr_alu
  import sysreg_spr_ctrl_pkg::*;
#(
  parameter int N = SPR_W
) (
  input  logic [1:0]   cmd,
  input  logic [N-1:0] base,
  input  logic [N-1:0] operand,
  output logic [N-1:0] result,
  output logic         write_en
);

  // Select the new SPR value for the requested command.
  always_comb begin
    result   = base;
    write_en = cmd_writes(cmd);
    case (exe_cmd_e'(cmd))
      EXE_CMD_SET: result = operand;
      EXE_CMD_ADD: result = base + operand;
      EXE_CMD_SUB: result = base - operand;
      default:     result = base;
    endcase
  end

endmodule

// File: rtl/sysreg_spr_ctrl.sv
// SPR write-port sequencer: arbitrates exception entry, exception return and
// execute-stage commands onto the SPR register, keeping a one-entry shadow of
// the interrupted user stack pointer.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | accepting requests (entry > return > execute)
//   ENTRY_SAVE | capture base into shadow if empty; launch KSP write + ack
//   ENTRY_LOAD | KSP write strobe and ack visible on the outputs
//   RET_LOAD   | shadow restore strobe (or error) and ack visible
//
// Outputs are registered, so each write/ack is decided one state earlier
// than the state in which it is seen on the pins.
module sysreg_spr_ctrl
  import sysreg_spr_ctrl_pkg::*;
#(
  parameter int N = SPR_W
) (
  input  logic         iCLOCK,
  input  logic         iRESET_SYNC,
  input  logic         iEXE_REQ,
  input  logic [1:0]   iEXE_CMD,
  input  logic [N-1:0] iEXE_DATA,
  output logic         oEXE_BUSY,
  input  logic         iEXCEPT_ENTRY_REQ,
  input  logic [N-1:0] iEXCEPT_KSP,
  input  logic         iEXCEPT_RETURN_REQ,
  output logic         oEXCEPT_ACK,
  output logic         oEXCEPT_ERR,
  output logic         oSPR_REGIST_REQ,
  output logic [N-1:0] oSPR_REGIST_DATA,
  input  logic [N-1:0] iSPR_INFO_DATA,
  output logic         oSHADOW_VALID,
  output logic [N-1:0] oSHADOW_DATA
);

  state_e       state_q, state_d;
  logic         shadow_valid_q, shadow_valid_d;
  logic [N-1:0] shadow_data_q, shadow_data_d;
  logic         regist_req_q, regist_req_d;
  logic [N-1:0] regist_data_q, regist_data_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;

  logic [N-1:0] base;
  logic [N-1:0] alu_result;
  logic         alu_write;

  // A write still in flight has not reached the register yet; use it as base.
  assign base = regist_req_q ? regist_data_q : iSPR_INFO_DATA;

  sysreg_spr_alu #(.N(N)) u_alu (
    .cmd      (iEXE_CMD),
    .base     (base),
    .operand  (iEXE_DATA),
    .result   (alu_result),
    .write_en (alu_write)
  );

  // Next-state, shadow and registered-output decisions.
  always_comb begin
    state_d        = state_q;
    shadow_valid_d = shadow_valid_q;
    shadow_data_d  = shadow_data_q;
    regist_req_d   = 1'b0;
    regist_data_d  = regist_data_q;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEXCEPT_ENTRY_REQ) begin
          state_d = ENTRY_SAVE;
        end else if (iEXCEPT_RETURN_REQ) begin
          state_d = RET_LOAD;
          ack_d   = 1'b1;
          if (shadow_valid_q) begin
            regist_req_d   = 1'b1;
            regist_data_d  = shadow_data_q;
            shadow_valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (iEXE_REQ) begin
          regist_req_d = alu_write;
          if (alu_write) begin
            regist_data_d = alu_result;
          end
        end
      end
      ENTRY_SAVE: begin
        // A nested entry keeps the outermost user stack pointer.
        if (!shadow_valid_q) begin
          shadow_data_d  = base;
          shadow_valid_d = 1'b1;
        end
        regist_req_d  = 1'b1;
        regist_data_d = iEXCEPT_KSP;
        ack_d         = 1'b1;
        state_d       = ENTRY_LOAD;
      end
      ENTRY_LOAD: state_d = IDLE;
      RET_LOAD:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q        <= IDLE;
      shadow_valid_q <= 1'b0;
      shadow_data_q  <= '0;
      regist_req_q   <= 1'b0;
      regist_data_q  <= '0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_data_q  <= shadow_data_d;
      regist_req_q   <= regist_req_d;
      regist_data_q  <= regist_data_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
    end
  end

  assign oEXE_BUSY        = (state_q != IDLE) | iEXCEPT_ENTRY_REQ | iEXCEPT_RETURN_REQ;
  assign oEXCEPT_ACK      = ack_q;
  assign oEXCEPT_ERR      = err_q;
  assign oSPR_REGIST_REQ  = regist_req_q;
  assign oSPR_REGIST_DATA = regist_data_q;
  assign oSHADOW_VALID    = shadow_valid_q;
  assign oSHADOW_DATA     = shadow_data_q;

endmodule

// File: tb/tb_sysreg_spr_ctrl.sv
// Bench for the SPR update sequencer: directed stimulus pushes expected
// write/ack events with their cycle stamp; a monitor pops and compares.
module tb_sysreg_spr_ctrl;
  import sysreg_spr_ctrl_pkg::*;

  localparam int N = 32;

  logic         iCLOCK = 1'b0;
  logic         iRESET_SYNC = 1'b1;
  logic         iEXE_REQ = 1'b0;
  logic [1:0]   iEXE_CMD = 2'b00;
  logic [N-1:0] iEXE_DATA = '0;
  logic         oEXE_BUSY;
  logic         iEXCEPT_ENTRY_REQ = 1'b0;
  logic [N-1:0] iEXCEPT_KSP = '0;
  logic         iEXCEPT_RETURN_REQ = 1'b0;
  logic         oEXCEPT_ACK;
  logic         oEXCEPT_ERR;
  logic         oSPR_REGIST_REQ;
  logic [N-1:0] oSPR_REGIST_DATA;
  logic [N-1:0] iSPR_INFO_DATA;
  logic         oSHADOW_VALID;
  logic [N-1:0] oSHADOW_DATA;

  sysreg_spr_ctrl #(.N(N)) dut (
    .iCLOCK             (iCLOCK),
    .iRESET_SYNC        (iRESET_SYNC),
    .iEXE_REQ           (iEXE_REQ),
    .iEXE_CMD           (iEXE_CMD),
    .iEXE_DATA          (iEXE_DATA),
    .oEXE_BUSY          (oEXE_BUSY),
    .iEXCEPT_ENTRY_REQ  (iEXCEPT_ENTRY_REQ),
    .iEXCEPT_KSP        (iEXCEPT_KSP),
    .iEXCEPT_RETURN_REQ (iEXCEPT_RETURN_REQ),
    .oEXCEPT_ACK        (oEXCEPT_ACK),
    .oEXCEPT_ERR        (oEXCEPT_ERR),
    .oSPR_REGIST_REQ    (oSPR_REGIST_REQ),
    .oSPR_REGIST_DATA   (oSPR_REGIST_DATA),
    .iSPR_INFO_DATA     (iSPR_INFO_DATA),
    .oSHADOW_VALID      (oSHADOW_VALID),
    .oSHADOW_DATA       (oSHADOW_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    int          cyc;
    logic        req;
    logic [31:0] data;
    logic        ack;
    logic        err;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  // Environment model of the SPR register itself.
  logic [N-1:0] spr_q = '0;
  always @(posedge iCLOCK) begin
    if (iRESET_SYNC) spr_q <= '0;
    else if (oSPR_REGIST_REQ) spr_q <= oSPR_REGIST_DATA;
  end
  assign iSPR_INFO_DATA = spr_q;

  // Monitor: every strobe/ack/err observation must match the next expected event.
  always @(negedge iCLOCK) begin
    ev_t e;
    if (iRESET_SYNC !== 1'b1 &&
        (oSPR_REGIST_REQ === 1'b1 || oEXCEPT_ACK === 1'b1 || oEXCEPT_ERR === 1'b1)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d actual req=%b data=%h ack=%b err=%b required none",
                 cyc, oSPR_REGIST_REQ, oSPR_REGIST_DATA, oEXCEPT_ACK, oEXCEPT_ERR);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || oSPR_REGIST_REQ !== e.req ||
            (e.req && oSPR_REGIST_DATA !== e.data) ||
            oEXCEPT_ACK !== e.ack || oEXCEPT_ERR !== e.err) begin
          fails++;
          $display("FAIL event actual cyc=%0d req=%b data=%h ack=%b err=%b required cyc=%0d req=%b data=%h ack=%b err=%b",
                   cyc, oSPR_REGIST_REQ, oSPR_REGIST_DATA, oEXCEPT_ACK, oEXCEPT_ERR,
                   e.cyc, e.req, e.data, e.ack, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic push(input int c, input logic req, input logic [31:0] d,
                      input logic ack, input logic err);
    ev_t e;
    e.cyc = c; e.req = req; e.data = d; e.ack = ack; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exe(input logic [1:0] cmd, input logic [31:0] d);
    iEXE_REQ  = 1'b1;
    iEXE_CMD  = cmd;
    iEXE_DATA = d;
  endtask

  initial begin
    int c;

    // Reset state
    repeat (3) tick();
    chk("rst_req", {31'd0, oSPR_REGIST_REQ}, 32'd0);
    chk("rst_data", oSPR_REGIST_DATA, 32'd0);
    chk("rst_ack_err", {30'd0, oEXCEPT_ACK, oEXCEPT_ERR}, 32'd0);
    chk("rst_shadow_valid", {31'd0, oSHADOW_VALID}, 32'd0);
    chk("rst_shadow_data", oSHADOW_DATA, 32'd0);
    chk("rst_busy", {31'd0, oEXE_BUSY}, 32'd0);
    iRESET_SYNC = 1'b0;
    tick();

    // Back-to-back set/add/sub with forwarding
    c = cyc;
    chk("exe_busy_idle", {31'd0, oEXE_BUSY}, 32'd0);
    exe(EXE_CMD_SET, 32'h1000); push(c + 1, 1'b1, 32'h1000, 1'b0, 1'b0);
    tick();
    exe(EXE_CMD_ADD, 32'h10);   push(c + 2, 1'b1, 32'h1010, 1'b0, 1'b0);
    tick();
    exe(EXE_CMD_SUB, 32'h4);    push(c + 3, 1'b1, 32'h100C, 1'b0, 1'b0);
    tick();
    iEXE_REQ = 1'b0;
    tick(); tick();

    // Reserved command: accepted, no write
    exe(EXE_CMD_NOP, 32'hDEAD);
    tick();
    iEXE_REQ = 1'b0;
    tick(); tick();
    chk("nop_spr_unchanged", spr_q, 32'h100C);

    // SPR = 0x2000, then entry with KSP = 0x8000
    c = cyc;
    exe(EXE_CMD_SET, 32'h2000); push(c + 1, 1'b1, 32'h2000, 1'b0, 1'b0);
    tick();
    iEXE_REQ = 1'b0;
    tick(); tick();
    c = cyc;
    iEXCEPT_ENTRY_REQ = 1'b1;
    iEXCEPT_KSP = 32'h8000;
    #1;
    chk("entry_busy", {31'd0, oEXE_BUSY}, 32'd1);
    push(c + 2, 1'b1, 32'h8000, 1'b1, 1'b0);
    tick(); tick(); tick();
    iEXCEPT_ENTRY_REQ = 1'b0;
    chk("entry_shadow_valid", {31'd0, oSHADOW_VALID}, 32'd1);
    chk("entry_shadow_data", oSHADOW_DATA, 32'h2000);
    tick();

    // Return restores the saved user stack
    c = cyc;
    iEXCEPT_RETURN_REQ = 1'b1;
    push(c + 1, 1'b1, 32'h2000, 1'b1, 1'b0);
    tick(); tick();
    iEXCEPT_RETURN_REQ = 1'b0;
    chk("ret_shadow_valid", {31'd0, oSHADOW_VALID}, 32'd0);
    tick();

    // Return with empty shadow: ack + err, no write
    c = cyc;
    iEXCEPT_RETURN_REQ = 1'b1;
    push(c + 1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick(); tick();
    iEXCEPT_RETURN_REQ = 1'b0;
    tick();

    // Entry, return and execute raised together
    c = cyc;
    iEXCEPT_ENTRY_REQ  = 1'b1;
    iEXCEPT_KSP        = 32'h9000;
    iEXCEPT_RETURN_REQ = 1'b1;
    exe(EXE_CMD_ADD, 32'h1);
    #1;
    chk("all3_busy_start", {31'd0, oEXE_BUSY}, 32'd1);
    push(c + 2, 1'b1, 32'h9000, 1'b1, 1'b0);
    push(c + 4, 1'b1, 32'h2000, 1'b1, 1'b0);
    push(c + 6, 1'b1, 32'h2001, 1'b0, 1'b0);
    tick(); tick(); tick();
    iEXCEPT_ENTRY_REQ = 1'b0;
    #1;
    chk("all3_busy_ret_pending", {31'd0, oEXE_BUSY}, 32'd1);
    tick();
    chk("all3_busy_ret_load", {31'd0, oEXE_BUSY}, 32'd1);
    tick();
    iEXCEPT_RETURN_REQ = 1'b0;
    #1;
    chk("all3_busy_clear", {31'd0, oEXE_BUSY}, 32'd0);
    tick();
    iEXE_REQ = 1'b0;
    tick(); tick();

    // Wrap-around both directions
    c = cyc;
    exe(EXE_CMD_SET, 32'hFFFF_FFFF); push(c + 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    exe(EXE_CMD_ADD, 32'h1);         push(c + 2, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    exe(EXE_CMD_SUB, 32'h1);         push(c + 3, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    iEXE_REQ = 1'b0;
    tick(); tick();

    // Reset while in ENTRY_SAVE
    iEXCEPT_ENTRY_REQ = 1'b1;
    iEXCEPT_KSP = 32'h1234;
    tick();
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    iEXCEPT_ENTRY_REQ = 1'b0;
    #1;
    chk("midrst_req", {31'd0, oSPR_REGIST_REQ}, 32'd0);
    chk("midrst_data", oSPR_REGIST_DATA, 32'd0);
    chk("midrst_ack_err", {30'd0, oEXCEPT_ACK, oEXCEPT_ERR}, 32'd0);
    chk("midrst_shadow_valid", {31'd0, oSHADOW_VALID}, 32'd0);
    chk("midrst_shadow_data", oSHADOW_DATA, 32'd0);
    chk("midrst_busy", {31'd0, oEXE_BUSY}, 32'd0);
    tick(); tick();

    // Recovery after reset
    c = cyc;
    exe(EXE_CMD_SET, 32'h42); push(c + 1, 1'b1, 32'h42, 1'b0, 1'b0);
    tick();
    iEXE_REQ = 1'b0;
    repeat (3) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
